writeback_arbiter: RTL
======================

// Module: writeback_arbiter
// PURPOSE
//   Collects completed results from NUM_SRC functional units and drives the two physical
//   register file write ports plus the matching ready-set ports each cycle. Sits between the
//   execute-stage FU outputs and the physical register file. Provides per-source one-entry
//   buffering, round-robin fairness and same-destination conflict avoidance.
// PARAMETERS
//   NUM_SRC        4               number of result sources (FUs); 2..8
//   XLEN           `XLEN           data width, from ooo_processor_defines.vh
//   PHYS_REG_BITS  `PHYS_REG_BITS  physical register address width, from the same defines
// PORTS
//   clk            in   1                      clock, all state on posedge
//   rst            in   1                      synchronous active-high reset
//   flush          in   1                      squash all buffered results (mispredict/exception)
//   src_valid      in   NUM_SRC                result valid per source
//   src_ready      out  NUM_SRC                arbiter can accept result from source i
//   src_addr       in   NUM_SRC*PHYS_REG_BITS  destination phys reg, source i at [i*PRB +: PRB]
//   src_data       in   NUM_SRC*XLEN           result data, source i at [i*XLEN +: XLEN]
//   write_enable1  out  1                      regfile write port 1 enable; also drives ready_set1
//   write_addr1    out  PHYS_REG_BITS          port 1 address; also drives ready_addr1
//   write_data1    out  XLEN                   port 1 data
//   write_enable2  out  1                      regfile write port 2 enable; also drives ready_set2
//   write_addr2    out  PHYS_REG_BITS          port 2 address; also drives ready_addr2
//   write_data2    out  XLEN                   port 2 data
//   pending_count  out  $clog2(NUM_SRC+1)      number of occupied slots
// BEHAVIOUR
//   - Reset (rst=1 at posedge): all slots invalid, rr_ptr=0; all write_* outputs 0; pending_count=0.
//   - Slot i holds {valid, addr, data}. src_ready[i] = !slot_valid[i] | grant[i]; the ready path is
//     combinational from the arbitration. A transfer occurs when src_valid[i] & src_ready[i]; the
//     slot loads at that posedge.
//   - Arbitration is combinational over the slots and runs every cycle.
//     - Scan the slots starting at rr_ptr, wrapping modulo NUM_SRC.
//     - The first valid slot is granted to port 1.
//     - The next valid slot whose addr differs from the port-1 addr is granted to port 2.
//     - A same-addr slot is skipped this cycle and stays buffered.
//   - Outputs are registered. The granted slot's contents appear on write_*1/2 in the cycle after
//     the grant, and the granted slot clears at the grant posedge. Latency from src accept to
//     write_enable is 2 cycles. The regfile commits one edge later.
//   - If no slot is granted to a port, its enable is 0 and its addr/data are held at their previous values.
//   - rr_ptr updates at each posedge that has any grant, to (last granted index + 1) mod NUM_SRC.
//     It is unchanged when there is no grant.
//   - A newly accepted result is not eligible for arbitration until the cycle after its slot loads.
//     There is no input-to-output bypass.
//   - flush (sync): at the posedge, clear all slots and both write enables, and block loads that
//     cycle. rr_ptr is unchanged. The flush takes priority over a load and over a grant.
//   - rst takes priority over flush. Asserting rst mid-operation discards all buffered results.
//   - Full condition: with all slots valid and 2 grants per cycle, at most 2 src_ready are high.
//   - Each result is written exactly once. Results are never dropped or duplicated absent flush/rst.
//   - Same-cycle writes to equal addresses are never issued (write_addr1 != write_addr2 whenever
//     both enables are 1).
//   - pending_count = popcount(slot_valid), registered with the slots.
// TESTING
//   1 Reset: hold rst 2 cycles -> write_enable1/2=0, pending_count=0, src_ready=4'b1111.
//   2 Single result: src0 valid, addr=40, data=32'hDEADBEEF at cycle 0 -> cycle 2: write_enable1=1,
//     write_addr1=40, data DEADBEEF; write_enable2=0.
//   3 Burst: srcs 0..3 valid, addr 33..36, rr_ptr=0 -> cycle 2: ports write 33/34; cycle 3: 35/36;
//     src_ready[3:2]=0 while those slots wait.
//   4 Conflict: src0 and src1 both addr=50, data A/B -> port1=50/A in one cycle, port1=50/B the next;
//     write_enable2=0 in both cycles.
//   5 Fairness: src0,src1 valid every cycle, one src3 result -> src3 written within 2 cycles of its
//     slot loading.
//   6 Flush: load 3 slots, assert flush for 1 cycle -> next cycle enables=0 and pending_count=0;
//     none of the 3 results is ever written.

Source files
------------

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: one-entry result buffer per FU feeding two regfile write ports.
// Ports: clk/rst/flush; src_valid/ready/addr/data per FU; write_enable/addr/data x2; pending_count.
module writeback_arbiter #(
  parameter int NUM_SRC       = 4,
  parameter int XLEN          = 32,
  parameter int PHYS_REG_BITS = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [NUM_SRC-1:0]               src_valid,
  output logic [NUM_SRC-1:0]               src_ready,
  input  logic [NUM_SRC*PHYS_REG_BITS-1:0] src_addr,
  input  logic [NUM_SRC*XLEN-1:0]          src_data,
  output logic                             write_enable1,
  output logic [PHYS_REG_BITS-1:0]         write_addr1,
  output logic [XLEN-1:0]                  write_data1,
  output logic                             write_enable2,
  output logic [PHYS_REG_BITS-1:0]         write_addr2,
  output logic [XLEN-1:0]                  write_data2,
  output logic [$clog2(NUM_SRC+1)-1:0]     pending_count
);

  localparam int IW  = $clog2(NUM_SRC);
  localparam int CW  = $clog2(NUM_SRC+1);
  localparam int PRB = PHYS_REG_BITS;

  logic [NUM_SRC-1:0] slot_valid;
  logic [PRB-1:0]     slot_addr [NUM_SRC];
  logic [XLEN-1:0]    slot_data [NUM_SRC];
  logic [IW-1:0]      rr_ptr;

  logic [IW-1:0]      scan_idx [NUM_SRC];
  logic               g1_vld;
  logic               g2_vld;
  logic [IW-1:0]      g1_idx;
  logic [IW-1:0]      g2_idx;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] load;
  logic [NUM_SRC-1:0] valid_nxt;
  logic [CW-1:0]      cnt_nxt;
  logic [IW-1:0]      last_idx;
  logic [IW-1:0]      rr_nxt;

  function automatic logic [IW-1:0] wrap(input int v);
    int w;
    w = (v >= NUM_SRC) ? v - NUM_SRC : v;
    return w[IW-1:0];
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_idx[k] = wrap(int'(rr_ptr) + k);
    end
  end

  // Port 2 takes the next valid slot whose destination differs
  // from port 1; equal destinations wait for a later cycle.
  always_comb begin
    g1_vld = 1'b0;
    g1_idx = '0;
    g2_vld = 1'b0;
    g2_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (slot_valid[scan_idx[k]]) begin
        if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_idx = scan_idx[k];
        end else if (!g2_vld &&
                     slot_addr[scan_idx[k]] != slot_addr[g1_idx]) begin
          g2_vld = 1'b1;
          g2_idx = scan_idx[k];
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (g1_vld) grant[g1_idx] = 1'b1;
    if (g2_vld) grant[g2_idx] = 1'b1;
  end

  assign src_ready = ~slot_valid | grant;
  assign load      = src_valid & src_ready;
  assign valid_nxt = (slot_valid & ~grant) | load;
  assign last_idx  = g2_vld ? g2_idx : g1_idx;
  assign rr_nxt    = wrap(int'(last_idx) + 1);

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cnt_nxt = cnt_nxt + CW'(valid_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid    <= '0;
      rr_ptr        <= '0;
      write_enable1 <= 1'b0;
      write_addr1   <= '0;
      write_data1   <= '0;
      write_enable2 <= 1'b0;
      write_addr2   <= '0;
      write_data2   <= '0;
      pending_count <= '0;
    end else if (flush) begin
      slot_valid    <= '0;
      write_enable1 <= 1'b0;
      write_enable2 <= 1'b0;
      pending_count <= '0;
    end else begin
      slot_valid    <= valid_nxt;
      pending_count <= cnt_nxt;
      if (g1_vld | g2_vld) rr_ptr <= rr_nxt;
      write_enable1 <= g1_vld;
      if (g1_vld) begin
        write_addr1 <= slot_addr[g1_idx];
        write_data1 <= slot_data[g1_idx];
      end
      write_enable2 <= g2_vld;
      if (g2_vld) begin
        write_addr2 <= slot_addr[g2_idx];
        write_data2 <= slot_data[g2_idx];
      end
    end
  end

  // Payload needs no reset: slot_valid qualifies it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (load[i]) begin
        slot_addr[i] <= src_addr[i*PRB +: PRB];
        slot_data[i] <= src_data[i*XLEN +: XLEN];
      end
    end
  end

endmodule
